// File: rtl/i2c_slave.sv
// I2C target at a fixed 7-bit address; oversamples SCL/SDA on clk, open-drain style drives.
// Optional clock stretching in the write ACK phase is enabled with `define I2C_STRETCH_EN.
//
// state    | meaning
// S_IDLE   | bus ignored until START
// S_ADDR   | shifting address byte
// S_AACK   | driving address ACK (and fetching first read byte)
// S_WR     | shifting a write byte
// S_WACK   | driving write-byte ACK
// S_RD     | presenting a read byte bit by bit
// S_RACK   | sampling master ACK/NACK of a read byte
// S_WAIT   | not addressed or read finished; wait for START/STOP
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sdain,
  output logic       sdaout,
  output logic       sclout,
  output logic [7:0] wrdata,
  output logic       wrvalid,
  input  logic       wrready,
  input  logic [7:0] rddata,
  output logic       rdreq,
  output logic       sel,
  output logic       rw
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RACK, S_WAIT
  } state_t;

  state_t     state, state_nx;
  logic [1:0] scl_q, sda_q;
  logic       scl_h, sda_h, scl_s, sda_s;
  logic       sclr, sclf, start, stop;
  logic [7:0] shift, shift_nx, wrdata_nx;
  logic [3:0] bitcnt, cnt_nx;
  logic       phase, phase_nx, rdreq_d;
  logic       sda_nx, scl_nx, sel_nx, rw_nx, rdreq_nx, wrvalid_nx;

  // Sync flops reset to the idle bus level so reset release never fakes a START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 2'b11;
      sda_q <= 2'b11;
      scl_h <= 1'b1;
      sda_h <= 1'b1;
    end else begin
      scl_q <= {scl_q[0], scl};
      sda_q <= {sda_q[0], sdain};
      scl_h <= scl_q[1];
      sda_h <= sda_q[1];
    end
  end

  assign scl_s = scl_q[1];
  assign sda_s = sda_q[1];
  assign sclr  = scl_s & ~scl_h;
  assign sclf  = ~scl_s & scl_h;
  assign start = scl_s & scl_h & sda_h & ~sda_s;
  assign stop  = scl_s & scl_h & ~sda_h & sda_s;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start)     state_nx = S_ADDR;
    else if (stop) state_nx = S_IDLE;
    else begin
      case (state)
        S_ADDR: if (sclr && bitcnt == 4'd7)
                  state_nx = (shift[6:0] == ADDR) ? S_AACK : S_WAIT;
        S_AACK: if (sclf && phase) state_nx = rw ? S_RD : S_WR;
        S_WR:   if (sclr && bitcnt == 4'd7) state_nx = S_WACK;
        S_WACK: if (sclf && phase) state_nx = S_WR;
        S_RD:   if (sclf && bitcnt == 4'd8) state_nx = S_RACK;
        S_RACK: begin
          if (sclr && !phase && sda_s) state_nx = S_WAIT;
          else if (sclf && phase)      state_nx = S_RD;
        end
        default: state_nx = state;
      endcase
    end
  end

  // phase marks the second half of an ACK slot (ACK driven / master ACK seen).
  always_comb begin
    sda_nx     = sdaout;
    scl_nx     = sclout;
    sel_nx     = sel;
    rw_nx      = rw;
    rdreq_nx   = 1'b0;
    wrvalid_nx = 1'b0;
    wrdata_nx  = wrdata;
    shift_nx   = shift;
    cnt_nx     = bitcnt;
    phase_nx   = phase;
    if (rdreq_d) shift_nx = rddata;
`ifdef I2C_STRETCH_EN
    if (!sclout && wrready) scl_nx = 1'b1;
`endif
    if (start) begin
      sda_nx   = 1'b1;
      sel_nx   = 1'b0;
      cnt_nx   = 4'd0;
      phase_nx = 1'b0;
    end else if (stop) begin
      sda_nx   = 1'b1;
      sel_nx   = 1'b0;
      phase_nx = 1'b0;
    end else begin
      case (state)
        S_ADDR: if (sclr) begin
          shift_nx = {shift[6:0], sda_s};
          cnt_nx   = bitcnt + 4'd1;
          if (bitcnt == 4'd7 && shift[6:0] == ADDR) begin
            sel_nx = 1'b1;
            rw_nx  = sda_s;
          end
        end
        S_AACK: begin
          if (sclf && !phase) begin
            sda_nx   = 1'b0;
            phase_nx = 1'b1;
          end else if (sclr && phase && rw) begin
            rdreq_nx = 1'b1;
          end else if (sclf && phase) begin
            sda_nx   = rw ? shift[7] : 1'b1;
            cnt_nx   = 4'd0;
            phase_nx = 1'b0;
          end
        end
        S_WR: if (sclr) begin
          shift_nx = {shift[6:0], sda_s};
          cnt_nx   = bitcnt + 4'd1;
          if (bitcnt == 4'd7) begin
            wrdata_nx  = {shift[6:0], sda_s};
            wrvalid_nx = 1'b1;
          end
        end
        S_WACK: begin
          if (sclf && !phase) begin
            sda_nx   = 1'b0;
            phase_nx = 1'b1;
          end else if (sclf && phase) begin
            sda_nx   = 1'b1;
            cnt_nx   = 4'd0;
            phase_nx = 1'b0;
`ifdef I2C_STRETCH_EN
            if (!wrready) scl_nx = 1'b0;
`endif
          end
        end
        S_RD: begin
          if (sclr) begin
            cnt_nx = bitcnt + 4'd1;
          end else if (sclf) begin
            if (bitcnt == 4'd8) begin
              sda_nx   = 1'b1;
              phase_nx = 1'b0;
            end else begin
              shift_nx = {shift[6:0], 1'b0};
              sda_nx   = shift[6];
            end
          end
        end
        S_RACK: begin
          if (sclr && !phase && !sda_s) begin
            rdreq_nx = 1'b1;
            phase_nx = 1'b1;
          end else if (sclf && phase) begin
            sda_nx   = shift[7];
            cnt_nx   = 4'd0;
            phase_nx = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sdaout  <= 1'b1;
      sclout  <= 1'b1;
      sel     <= 1'b0;
      rw      <= 1'b0;
      rdreq   <= 1'b0;
      rdreq_d <= 1'b0;
      wrvalid <= 1'b0;
      wrdata  <= 8'h00;
      shift   <= 8'h00;
      bitcnt  <= 4'd0;
      phase   <= 1'b0;
    end else begin
      sdaout  <= sda_nx;
      sclout  <= scl_nx;
      sel     <= sel_nx;
      rw      <= rw_nx;
      rdreq   <= rdreq_nx;
      rdreq_d <= rdreq;
      wrvalid <= wrvalid_nx;
      wrdata  <= wrdata_nx;
      shift   <= shift_nx;
      bitcnt  <= cnt_nx;
      phase   <= phase_nx;
    end
  end

`ifndef I2C_STRETCH_EN
  logic unused_wrready;
  assign unused_wrready = wrready;
`endif

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: wired-AND bus master model, user-side responder, counters.
module tb_i2c_slave;

  logic       clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, wrready = 1'b1;
  logic [7:0] rddata = 8'h00;
  logic       sdaout, sclout, wrvalid, rdreq, sel, rw;
  logic [7:0] wrdata;
  logic       scl_line, sda_line;

  int total = 0, bad = 0;
  int wr_cnt = 0, rd_cnt = 0, scl_low_cnt = 0, sda_low_cnt = 0, sel_cnt = 0, rd_idx = 0;
  logic [7:0] last_wr = 8'h00;
  logic [7:0] rd_q [3] = '{8'hA5, 8'h3C, 8'hC3};

  assign scl_line = scl_m & sclout;
  assign sda_line = sda_m & sdaout;

  i2c_slave #(.ADDR(7'h54)) dut (
    .clk(clk), .rst(rst), .scl(scl_line), .sdain(sda_line),
    .sdaout(sdaout), .sclout(sclout), .wrdata(wrdata), .wrvalid(wrvalid),
    .wrready(wrready), .rddata(rddata), .rdreq(rdreq), .sel(sel), .rw(rw)
  );

  always #5 clk = ~clk;

  // User side: next read byte presented in the cycle after rdreq.
  always @(negedge clk) begin
    if (wrvalid) begin wr_cnt++; last_wr = wrdata; end
    if (rdreq) begin
      rd_cnt++;
      if (rd_idx < 3) begin rddata = rd_q[rd_idx]; rd_idx++; end
    end
    if (!sclout) scl_low_cnt++;
    if (!sdaout) sda_low_cnt++;
    if (sel) sel_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_high();
    int i = 0;
    while (!scl_line && i < 400) begin tick(1); i++; end
    if (!scl_line) check("scl_release", scl_line, 1);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    tick(4); sda_m = b;
    tick(4); scl_m = 1'b1;
    wait_high();
    tick(4); r = sda_line;
    tick(4); scl_m = 1'b0;
  endtask

  task automatic bus_start();
    tick(4); sda_m = 1'b1;
    tick(4); scl_m = 1'b1;
    wait_high();
    tick(8); sda_m = 1'b0;
    tick(8); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(4); sda_m = 1'b0;
    tick(4); scl_m = 1'b1;
    wait_high();
    tick(8); sda_m = 1'b1;
    tick(8);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
    xfer_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic ackline);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin xfer_bit(1'b1, r); d = {d[6:0], r}; end
    xfer_bit(~mack, ackline);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic       ack, r, ackline;
    logic [7:0] d, a;
    int         w0, r0, s0, l0;

    tick(5);
    check("rst_sdaout", sdaout, 1);
    check("rst_sclout", sclout, 1);
    check("rst_wrdata", wrdata, 0);
    check("rst_wrvalid", wrvalid, 0);
    check("rst_rdreq", rdreq, 0);
    check("rst_sel", sel, 0);
    check("rst_rw", rw, 0);
    rst = 1'b0;
    tick(5);

    // Single-byte write.
    bus_start();
    write_byte(8'hA8, ack);
    check("t1_addr_ack", ack, 1);
    check("t1_sel_on", sel, 1);
    check("t1_rw", rw, 0);
    write_byte(8'h01, ack);
    check("t1_data_ack", ack, 1);
    check("t1_sel_held", sel, 1);
    bus_stop();
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_wrdata", last_wr, 8'h01);
    check("t1_sel_off", sel, 0);
    check("t1_rd_cnt", rd_cnt, 0);

    // Other address: target must stay silent.
    s0 = sda_low_cnt; l0 = sel_cnt;
    bus_start();
    write_byte(8'h68, ack);
    check("t2_addr_nack", ack, 0);
    write_byte(8'h55, ack);
    check("t2_data_nack", ack, 0);
    bus_stop();
    check("t2_sda_low", sda_low_cnt - s0, 0);
    check("t2_sel_cnt", sel_cnt - l0, 0);
    check("t2_wr_cnt", wr_cnt, 1);
    check("t2_rd_cnt", rd_cnt, 0);

    // Single-byte read, master NACK.
    bus_start();
    write_byte(8'hA9, ack);
    check("t3_addr_ack", ack, 1);
    check("t3_rw", rw, 1);
    read_byte(1'b0, d, ackline);
    check("t3_rdbyte", d, 8'hA5);
    check("t3_released", ackline, 1);
    bus_stop();
    check("t3_rd_cnt", rd_cnt, 1);

    // Two-byte read, then repeated START into a write.
    w0 = wr_cnt; r0 = rd_cnt;
    bus_start();
    write_byte(8'hA9, ack);
    check("t4_addr_ack", ack, 1);
    read_byte(1'b1, d, ackline);
    check("t4_byte0", d, 8'h3C);
    read_byte(1'b0, d, ackline);
    check("t4_byte1", d, 8'hC3);
    check("t4_rd_cnt", rd_cnt - r0, 2);
    bus_start();
    write_byte(8'hA8, ack);
    check("t4_waddr_ack", ack, 1);
    check("t4_rw", rw, 0);
    write_byte(8'h7E, ack);
    bus_stop();
    check("t4_wrdata", last_wr, 8'h7E);
    check("t4_wr_cnt", wr_cnt - w0, 1);
    check("t4_rd_total", rd_cnt - r0, 2);

    // STOP after a partial data byte.
    w0 = wr_cnt;
    bus_start();
    write_byte(8'hA8, ack);
    xfer_bit(1'b1, r); xfer_bit(1'b0, r); xfer_bit(1'b1, r); xfer_bit(1'b0, r);
    bus_stop();
    check("t5_no_wrvalid", wr_cnt - w0, 0);
    check("t5_sel", sel, 0);

    // Reset during the address ACK low phase.
    bus_start();
    a = 8'hA8;
    for (int i = 7; i >= 0; i--) xfer_bit(a[i], r);
    tick(6);
    check("t6_ack_low", sdaout, 0);
    rst = 1'b1;
    tick(1);
    check("t6_rst_sda", sdaout, 1);
    check("t6_rst_sel", sel, 0);
    rst = 1'b0;
    xfer_bit(1'b1, r);
    check("t6_bus_free", r, 1);
    bus_stop();
    bus_start();
    write_byte(8'hA8, ack);
    check("t6_recover_ack", ack, 1);
    write_byte(8'h99, ack);
    bus_stop();
    check("t6_recover_data", last_wr, 8'h99);

    // Write with the user holding off after one byte.
    w0 = wr_cnt;
    bus_start();
    write_byte(8'hA8, ack);
    wrready = 1'b0;
    write_byte(8'h11, ack);
    l0 = scl_low_cnt;
    fork
      begin tick(50); wrready = 1'b1; end
    join_none
    write_byte(8'h22, ack);
    check("t7_ack", ack, 1);
    bus_stop();
    check("t7_wrdata", last_wr, 8'h22);
    check("t7_wr_cnt", wr_cnt - w0, 2);
`ifdef I2C_STRETCH_EN
    check("t7_stretch_len", ((scl_low_cnt - l0) >= 44 && (scl_low_cnt - l0) <= 52), 1);
    check("t7_scl_released", sclout, 1);
`else
    check("t7_no_stretch", scl_low_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
